// File: rtl/freq_detect_if.sv
// freq_detect_if: FFT RAM 1 read port, start pulse and peak-detect results.
// The slave modport is the freq_detect side; master is its environment.
interface freq_detect_if;
    logic        fftdone;
    logic [27:0] ramq1;
    logic [9:0]  rdaddr1;
    logic [9:0]  maxbin;
    logic [27:0] maxpwr;
    logic        busy;
    logic        detectdone;
    logic        nodetect;

    modport slave (
        input  fftdone,
        input  ramq1,
        output rdaddr1,
        output maxbin,
        output maxpwr,
        output busy,
        output detectdone,
        output nodetect
    );

    modport master (
        output fftdone,
        output ramq1,
        input  rdaddr1,
        input  maxbin,
        input  maxpwr,
        input  busy,
        input  detectdone,
        input  nodetect
    );
endinterface

// File: rtl/freq_detect.sv
// freq_detect: scans FFT bins BINLO..BINHI of RAM 1, computes |X|^2 per bin
// and reports the lowest-indexed bin of maximum power. After the scan the RAM
// read address is parked on the peak bin so ramq1 carries its sample when the
// done pulse fires. Optional macro FD_THRESH_EN adds a minimum-power
// threshold that turns a weak peak into a nodetect pulse.
module freq_detect #(
    parameter int unsigned BINLO = 1,
    parameter int unsigned BINHI = 511,
    parameter int unsigned RDLAT = 2
`ifdef FD_THRESH_EN
    ,
    parameter logic [27:0] PWR_THRESH = 28'd4096
`endif
) (
    input  logic          clk,
    input  logic          reset,
    freq_detect_if.slave  bus
);

    localparam int unsigned AW    = 10;
    localparam int unsigned DW    = 28;
    localparam int unsigned CW    = 14;
    localparam int unsigned CNT_W = $clog2(RDLAT + 2);

    localparam logic [AW-1:0]    BIN_LO_A     = AW'(BINLO);
    localparam logic [AW-1:0]    BIN_HI_A     = AW'(BINHI);
    localparam logic [CNT_W-1:0] DRAIN_LAST   = CNT_W'(RDLAT);
    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(RDLAT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCAN,
        S_DRAIN,
        S_SETTLE,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [AW-1:0]       rdaddr_q, rdaddr_d;
    logic [AW-1:0]       maxbin_q, maxbin_d;
    logic [DW-1:0]       maxpwr_q, maxpwr_d;
    logic                busy_q, busy_d;
    logic                detect_q, detect_d;
`ifdef FD_THRESH_EN
    logic                nodetect_q, nodetect_d;
`endif

    // Valid tag and bin index travelling alongside the RAM read latency
    logic [RDLAT-1:0]    tag_q, tag_d;
    logic [AW-1:0]       bin_q [RDLAT];
    logic [AW-1:0]       bin_d [RDLAT];

    // Registered power stage
    logic [DW-1:0]       pwr_q, pwr_d;
    logic                pwr_vld_q, pwr_vld_d;
    logic [AW-1:0]       pwr_bin_q, pwr_bin_d;

    // Running maximum during the scan
    logic [DW-1:0]       run_max_q, run_max_d;
    logic [AW-1:0]       run_bin_q, run_bin_d;

    logic signed [CW-1:0] re_c, im_c;
    logic signed [DW-1:0] re_sq_c, im_sq_c;

    // Squares are non-negative and at most 2^26, so their sum (<= 2^27) fits 28b unsigned
    assign re_c    = bus.ramq1[27:14];
    assign im_c    = bus.ramq1[13:0];
    assign re_sq_c = re_c * re_c;
    assign im_sq_c = im_c * im_c;

    // Next-state, datapath and output computation
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rdaddr_d  = rdaddr_q;
        maxbin_d  = maxbin_q;
        maxpwr_d  = maxpwr_q;
        busy_d    = busy_q;
        detect_d  = 1'b0;
`ifdef FD_THRESH_EN
        nodetect_d = 1'b0;
`endif

        tag_d[0] = (state_q == S_SCAN);
        bin_d[0] = rdaddr_q;
        for (int i = 1; i < RDLAT; i++) begin
            tag_d[i] = tag_q[i-1];
            bin_d[i] = bin_q[i-1];
        end

        pwr_d     = $unsigned(re_sq_c) + $unsigned(im_sq_c);
        pwr_vld_d = tag_q[RDLAT-1];
        pwr_bin_d = bin_q[RDLAT-1];

        // Strict greater-than on ascending bins keeps the lowest bin on ties
        run_max_d = run_max_q;
        run_bin_d = run_bin_q;
        if (state_q == S_IDLE && bus.fftdone) begin
            run_max_d = '0;
            run_bin_d = BIN_LO_A;
        end else if (pwr_vld_q && (pwr_q > run_max_q)) begin
            run_max_d = pwr_q;
            run_bin_d = pwr_bin_q;
        end

        case (state_q)
            S_IDLE: begin
                rdaddr_d = maxbin_q;
                if (bus.fftdone) begin
                    state_d  = S_SCAN;
                    rdaddr_d = BIN_LO_A;
                    busy_d   = 1'b1;
                end
            end
            S_SCAN: begin
                if (rdaddr_q == BIN_HI_A) begin
                    state_d = S_DRAIN;
                    cnt_d   = '0;
                end else begin
                    rdaddr_d = rdaddr_q + AW'(1);
                end
            end
            S_DRAIN: begin
                // The last compare lands on this exit edge, so publish the next running max
                if (cnt_q == DRAIN_LAST) begin
                    state_d  = S_SETTLE;
                    cnt_d    = '0;
                    maxbin_d = run_bin_d;
                    maxpwr_d = run_max_d;
                    rdaddr_d = run_bin_d;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_SETTLE: begin
                rdaddr_d = maxbin_q;
                if (cnt_q == SETTLE_LAST) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
`ifdef FD_THRESH_EN
                    detect_d   = (maxpwr_q >= PWR_THRESH);
                    nodetect_d = (maxpwr_q <  PWR_THRESH);
`else
                    detect_d   = 1'b1;
`endif
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                state_d  = S_IDLE;
                rdaddr_d = maxbin_q;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, pipeline and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            rdaddr_q   <= '0;
            maxbin_q   <= '0;
            maxpwr_q   <= '0;
            busy_q     <= 1'b0;
            detect_q   <= 1'b0;
`ifdef FD_THRESH_EN
            nodetect_q <= 1'b0;
`endif
            tag_q      <= '0;
            for (int i = 0; i < RDLAT; i++) begin
                bin_q[i] <= '0;
            end
            pwr_q      <= '0;
            pwr_vld_q  <= 1'b0;
            pwr_bin_q  <= '0;
            run_max_q  <= '0;
            run_bin_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rdaddr_q   <= rdaddr_d;
            maxbin_q   <= maxbin_d;
            maxpwr_q   <= maxpwr_d;
            busy_q     <= busy_d;
            detect_q   <= detect_d;
`ifdef FD_THRESH_EN
            nodetect_q <= nodetect_d;
`endif
            tag_q      <= tag_d;
            for (int i = 0; i < RDLAT; i++) begin
                bin_q[i] <= bin_d[i];
            end
            pwr_q      <= pwr_d;
            pwr_vld_q  <= pwr_vld_d;
            pwr_bin_q  <= pwr_bin_d;
            run_max_q  <= run_max_d;
            run_bin_q  <= run_bin_d;
        end
    end

    assign bus.rdaddr1    = rdaddr_q;
    assign bus.maxbin     = maxbin_q;
    assign bus.maxpwr     = maxpwr_q;
    assign bus.busy       = busy_q;
    assign bus.detectdone = detect_q;
`ifdef FD_THRESH_EN
    assign bus.nodetect   = nodetect_q;
`else
    assign bus.nodetect   = 1'b0;
`endif

endmodule

// File: tb/tb_freq_detect.sv
// tb_freq_detect: directed scenarios for freq_detect against a 2-cycle-latency
// RAM model. Expected values are hand-computed from the test-plan vectors.
module tb_freq_detect;

    localparam int N        = 511;
    localparam int T_PULSE  = 517;
    localparam int T_FINAL  = 515;
    localparam int RUN_CYC  = 540;

    logic clk = 1'b0;
    logic reset;

    freq_detect_if u_if ();

    freq_detect u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (u_if)
    );

    always #5 clk = ~clk;

    // RAM 1 model, address to data in two cycles
    logic [27:0] mem [0:1023];
    logic [27:0] ram_p1;
    always @(posedge clk) begin
        ram_p1      <= mem[u_if.rdaddr1];
        u_if.ramq1  <= ram_p1;
    end

    int nvec = 0;
    int nerr = 0;

    // Observations from one scan run
    int          pulse_cyc, n_det, n_nd;
    logic [9:0]  p_maxbin, p_rdaddr, pre_maxbin, fin_maxbin, fin_rdaddr, addr_c1, addr_cn;
    logic [27:0] p_maxpwr, p_ramq1, end_ramq1;
    logic        p_busy, busy_c1, busy_last;
    logic [9:0]  rs_maxbin, rs_rdaddr;
    logic [27:0] rs_maxpwr;
    logic        rs_busy, rs_det, rs_nd;

    function automatic logic [27:0] mk(input int re, input int im);
        return {14'(re), 14'(im)};
    endfunction

    task automatic fill(input logic [27:0] v);
        for (int i = 0; i < 1024; i++) mem[i] = v;
    endtask

    // Pulse fftdone (cycle 0) and observe RUN_CYC cycles; optional extra fftdone / reset
    task automatic run_scan(input int fft2_cyc, input int rst_cyc);
        pulse_cyc = -1;
        n_det     = 0;
        n_nd      = 0;
        @(negedge clk);
        u_if.fftdone = 1'b1;
        for (int c = 1; c <= RUN_CYC; c++) begin
            @(negedge clk);
            u_if.fftdone = (c == fft2_cyc);
            reset        = (c == rst_cyc);
            if (u_if.detectdone === 1'b1) n_det++;
            if (u_if.nodetect === 1'b1) n_nd++;
            if ((u_if.detectdone === 1'b1 || u_if.nodetect === 1'b1) && pulse_cyc < 0) begin
                pulse_cyc = c;
                p_maxbin  = u_if.maxbin;
                p_maxpwr  = u_if.maxpwr;
                p_ramq1   = u_if.ramq1;
                p_rdaddr  = u_if.rdaddr1;
                p_busy    = u_if.busy;
            end
            if (c == 1) begin
                busy_c1 = u_if.busy;
                addr_c1 = u_if.rdaddr1;
            end
            if (c == N)           addr_cn    = u_if.rdaddr1;
            if (c == T_FINAL - 1) pre_maxbin = u_if.maxbin;
            if (c == T_FINAL) begin
                fin_maxbin = u_if.maxbin;
                fin_rdaddr = u_if.rdaddr1;
            end
            if (c == T_PULSE - 1) busy_last = u_if.busy;
            if (c == rst_cyc + 1) begin
                rs_maxbin = u_if.maxbin;
                rs_maxpwr = u_if.maxpwr;
                rs_rdaddr = u_if.rdaddr1;
                rs_busy   = u_if.busy;
                rs_det    = u_if.detectdone;
                rs_nd     = u_if.nodetect;
            end
            if (c == RUN_CYC) end_ramq1 = u_if.ramq1;
        end
        u_if.fftdone = 1'b0;
        reset        = 1'b0;
    endtask

    task automatic test_reset();
        reset        = 1'b1;
        u_if.fftdone = 1'b0;
        fill(28'd0);
        repeat (4) @(negedge clk);
        nvec++; if (u_if.maxbin !== 10'd0) begin nerr++; $display("FAIL reset_maxbin got %0d want 0", u_if.maxbin); end
        nvec++; if (u_if.maxpwr !== 28'd0) begin nerr++; $display("FAIL reset_maxpwr got %0d want 0", u_if.maxpwr); end
        nvec++; if (u_if.rdaddr1 !== 10'd0) begin nerr++; $display("FAIL reset_rdaddr got %0d want 0", u_if.rdaddr1); end
        nvec++; if (u_if.busy !== 1'b0) begin nerr++; $display("FAIL reset_busy got %b want 0", u_if.busy); end
        nvec++; if (u_if.detectdone !== 1'b0) begin nerr++; $display("FAIL reset_detectdone got %b want 0", u_if.detectdone); end
        nvec++; if (u_if.nodetect !== 1'b0) begin nerr++; $display("FAIL reset_nodetect got %b want 0", u_if.nodetect); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_tone();
        fill(28'd0);
        mem[37] = mk(1000, -500);
        run_scan(-1, -1);
        nvec++; if (pulse_cyc !== T_PULSE) begin nerr++; $display("FAIL tone_pulse_cycle got %0d want %0d", pulse_cyc, T_PULSE); end
        nvec++; if (n_det !== 1 || n_nd !== 0) begin nerr++; $display("FAIL tone_pulse_count got det=%0d nd=%0d want det=1 nd=0", n_det, n_nd); end
        nvec++; if (p_maxbin !== 10'd37) begin nerr++; $display("FAIL tone_maxbin got %0d want 37", p_maxbin); end
        nvec++; if (p_maxpwr !== 28'd1250000) begin nerr++; $display("FAIL tone_maxpwr got %0d want 1250000", p_maxpwr); end
        nvec++; if (p_ramq1 !== mk(1000, -500)) begin nerr++; $display("FAIL tone_ramq1 got %h want %h", p_ramq1, mk(1000, -500)); end
        nvec++; if (p_rdaddr !== 10'd37) begin nerr++; $display("FAIL tone_rdaddr_pulse got %0d want 37", p_rdaddr); end
        nvec++; if (p_busy !== 1'b0) begin nerr++; $display("FAIL tone_busy_at_pulse got %b want 0", p_busy); end
        nvec++; if (busy_c1 !== 1'b1 || busy_last !== 1'b1) begin nerr++; $display("FAIL tone_busy_window got c1=%b c516=%b want 1 1", busy_c1, busy_last); end
        nvec++; if (addr_c1 !== 10'd1) begin nerr++; $display("FAIL tone_first_addr got %0d want 1", addr_c1); end
        nvec++; if (addr_cn !== 10'd511) begin nerr++; $display("FAIL tone_last_addr got %0d want 511", addr_cn); end
        nvec++; if (pre_maxbin !== 10'd0) begin nerr++; $display("FAIL tone_maxbin_before_final got %0d want 0", pre_maxbin); end
        nvec++; if (fin_maxbin !== 10'd37 || fin_rdaddr !== 10'd37) begin nerr++; $display("FAIL tone_final_cycle got maxbin=%0d rdaddr=%0d want 37 37", fin_maxbin, fin_rdaddr); end
        nvec++; if (end_ramq1 !== mk(1000, -500)) begin nerr++; $display("FAIL tone_idle_ramq1 got %h want %h", end_ramq1, mk(1000, -500)); end
    endtask

    task automatic test_tie_range();
        fill(28'd0);
        mem[0]   = mk(8191, 8191);
        mem[600] = mk(8191, 8191);
        mem[20]  = mk(4000, 0);
        mem[300] = mk(4000, 0);
        run_scan(-1, -1);
        nvec++; if (pulse_cyc !== T_PULSE) begin nerr++; $display("FAIL tie_pulse_cycle got %0d want %0d", pulse_cyc, T_PULSE); end
        nvec++; if (pre_maxbin !== 10'd37) begin nerr++; $display("FAIL tie_maxbin_held got %0d want 37", pre_maxbin); end
        nvec++; if (p_maxbin !== 10'd20) begin nerr++; $display("FAIL tie_maxbin got %0d want 20", p_maxbin); end
        nvec++; if (p_maxpwr !== 28'd16000000) begin nerr++; $display("FAIL tie_maxpwr got %0d want 16000000", p_maxpwr); end
        nvec++; if (p_ramq1 !== mk(4000, 0)) begin nerr++; $display("FAIL tie_ramq1 got %h want %h", p_ramq1, mk(4000, 0)); end
    endtask

    task automatic test_extremes();
        fill(mk(100, 100));
        mem[511] = mk(-8192, -8192);
        run_scan(-1, -1);
        nvec++; if (pulse_cyc !== T_PULSE || n_det !== 1) begin nerr++; $display("FAIL ext_pulse got cyc=%0d det=%0d want %0d 1", pulse_cyc, n_det, T_PULSE); end
        nvec++; if (p_maxbin !== 10'd511) begin nerr++; $display("FAIL ext_maxbin got %0d want 511", p_maxbin); end
        nvec++; if (p_maxpwr !== 28'd134217728) begin nerr++; $display("FAIL ext_maxpwr got %0d want 134217728", p_maxpwr); end
        nvec++; if (p_ramq1 !== mk(-8192, -8192)) begin nerr++; $display("FAIL ext_ramq1 got %h want %h", p_ramq1, mk(-8192, -8192)); end
    endtask

    task automatic test_threshold();
        fill(mk(10, 10));
        run_scan(-1, -1);
        nvec++; if (pulse_cyc !== T_PULSE) begin nerr++; $display("FAIL thr_pulse_cycle got %0d want %0d", pulse_cyc, T_PULSE); end
`ifdef FD_THRESH_EN
        nvec++; if (n_nd !== 1 || n_det !== 0) begin nerr++; $display("FAIL thr_pulse_kind got det=%0d nd=%0d want det=0 nd=1", n_det, n_nd); end
`else
        nvec++; if (n_det !== 1 || n_nd !== 0) begin nerr++; $display("FAIL thr_pulse_kind got det=%0d nd=%0d want det=1 nd=0", n_det, n_nd); end
`endif
        nvec++; if (p_maxbin !== 10'd1) begin nerr++; $display("FAIL thr_maxbin got %0d want 1", p_maxbin); end
        nvec++; if (p_maxpwr !== 28'd200) begin nerr++; $display("FAIL thr_maxpwr got %0d want 200", p_maxpwr); end
    endtask

    task automatic test_midscan_fftdone();
        fill(28'd0);
        mem[37] = mk(1000, -500);
        run_scan(100, -1);
        nvec++; if (pulse_cyc !== T_PULSE || n_det !== 1 || n_nd !== 0) begin nerr++; $display("FAIL mid_fft_pulse got cyc=%0d det=%0d nd=%0d want %0d 1 0", pulse_cyc, n_det, n_nd, T_PULSE); end
        nvec++; if (p_maxbin !== 10'd37 || p_maxpwr !== 28'd1250000) begin nerr++; $display("FAIL mid_fft_result got bin=%0d pwr=%0d want 37 1250000", p_maxbin, p_maxpwr); end
    endtask

    task automatic test_midscan_reset();
        fill(28'd0);
        mem[20] = mk(4000, 0);
        run_scan(-1, 300);
        nvec++; if (rs_maxbin !== 10'd0 || rs_maxpwr !== 28'd0 || rs_rdaddr !== 10'd0) begin nerr++; $display("FAIL rst_outputs got bin=%0d pwr=%0d addr=%0d want 0 0 0", rs_maxbin, rs_maxpwr, rs_rdaddr); end
        nvec++; if (rs_busy !== 1'b0 || rs_det !== 1'b0 || rs_nd !== 1'b0) begin nerr++; $display("FAIL rst_flags got busy=%b det=%b nd=%b want 0 0 0", rs_busy, rs_det, rs_nd); end
        nvec++; if (pulse_cyc !== -1 || n_det !== 0 || n_nd !== 0) begin nerr++; $display("FAIL rst_no_pulse got cyc=%0d det=%0d nd=%0d want -1 0 0", pulse_cyc, n_det, n_nd); end
    endtask

    task automatic test_rescan();
        fill(mk(100, 100));
        mem[511] = mk(-8192, -8192);
        mem[5]   = mk(-8192, -8192);
        run_scan(-1, -1);
        nvec++; if (pulse_cyc !== T_PULSE || n_det !== 1) begin nerr++; $display("FAIL rescan_pulse got cyc=%0d det=%0d want %0d 1", pulse_cyc, n_det, T_PULSE); end
        nvec++; if (p_maxbin !== 10'd5 || p_maxpwr !== 28'd134217728) begin nerr++; $display("FAIL rescan_result got bin=%0d pwr=%0d want 5 134217728", p_maxbin, p_maxpwr); end
    endtask

    initial begin
        u_if.fftdone = 1'b0;
        reset        = 1'b1;
        test_reset();
        test_single_tone();
        test_tie_range();
        test_extremes();
        test_threshold();
        test_midscan_fftdone();
        test_midscan_reset();
        test_rescan();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
